ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 set-2 scan-code tracker, placed between the PS/2 receiver and the UI/control FSMs.

---
 rtl/ps2_key_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns a stream of PS/2 set-2 scan-code bytes into per-key state.
//   E0 (extended) and F0 (break) prefixes are parsed. Each completed code is
//   looked up in a table of NUM_KEYS {ext,code} entries. Typematic resends
//   from the keyboard are suppressed. The block can also generate its own
//   auto-repeat press pulses for the most recently pressed key.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   rx_done_tick  in   one-cycle strobe: scan_code is valid
//   scan_code     in   received byte
//   key_held      out  level per key: key currently down
//   key_press     out  one-cycle pulse per key: make, or internal auto-repeat
//   key_release   out  one-cycle pulse per key: break of a held key
//   any_held      out  OR of key_held
//   last_idx      out  index of the most recently pressed key
//   unknown_tick  out  one-cycle pulse: completed code matched no table entry

module ps2_key_tracker #(
  parameter int NUM_KEYS = 8,
  parameter logic [9*NUM_KEYS-1:0] KEY_TABLE = {9'h174, 9'h16B, 9'h172, 9'h175,
                                                9'h05A, 9'h04D, 9'h02C, 9'h021},
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_RATE    = 5000000,
  parameter int PREFIX_TIMEOUT = 2000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            scan_code,
  output logic [NUM_KEYS-1:0]   key_held,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic                  any_held,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] last_idx,
  output logic                  unknown_tick
);

  localparam int  LIW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int  MAX_DR = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int  CNTMAX = (MAX_DR > PREFIX_TIMEOUT) ? MAX_DR : PREFIX_TIMEOUT;
  localparam int  CW     = $clog2(CNTMAX + 1);
  localparam bit  REP_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EBRK} state_t;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Keyboard housekeeping bytes (BAT ok, ack, resend, echo, errors, pause lead-in).
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF) || (b == 8'hE1);
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         pto_q, pto_d;
  logic [CW-1:0]         rep_cnt_q, rep_cnt_d;
  logic                  rep_act_q, rep_act_d;
  logic                  rep_phase_q, rep_phase_d;
  logic [NUM_KEYS-1:0]   key_held_q, key_held_d;
  logic [NUM_KEYS-1:0]   key_press_q, key_press_d;
  logic [NUM_KEYS-1:0]   key_release_q, key_release_d;
  logic [LIW-1:0]        last_idx_q, last_idx_d;
  logic                  unknown_q, unknown_d;

  logic                  make_c, brk_c, ext_c;
  logic                  hit;
  logic [LIW-1:0]        hit_idx;
  logic                  press_evt, release_evt, unknown_evt, tick_evt;
  logic                  rep_fire;

  // ---- stage: parser state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pto_q   <= '0;
    end else begin
      state_q <= state_d;
      pto_q   <= pto_d;
    end
  end

  // Parser next state; an idle prefix state falls back to IDLE once the
  // timeout counter has seen PREFIX_TIMEOUT tick-free cycles.
  always_comb begin
    state_d = state_q;
    pto_d   = (rx_done_tick || state_q == S_IDLE) ? '0 : sat_inc(pto_q);
    if (rx_done_tick) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == 8'hE0)      state_d = S_EXT;
          else if (scan_code == 8'hF0) state_d = S_BRK;
        end
        S_EXT:   state_d = (scan_code == 8'hF0) ? S_EBRK : S_IDLE;
        S_BRK:   state_d = S_IDLE;
        S_EBRK:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && pto_q == CW'(PREFIX_TIMEOUT - 1)) begin
      state_d = S_IDLE;
    end
  end

  // Parser outputs: which kind of code (if any) this tick completes.
  always_comb begin
    make_c = 1'b0;
    brk_c  = 1'b0;
    ext_c  = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        S_IDLE: make_c = (scan_code != 8'hE0) && (scan_code != 8'hF0) &&
                         !is_ignored(scan_code);
        S_EXT: begin
          make_c = (scan_code != 8'hF0);
          ext_c  = 1'b1;
        end
        S_BRK:  brk_c = 1'b1;
        S_EBRK: begin
          brk_c = 1'b1;
          ext_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table lookup: scanning downward leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_TABLE[9*i +: 9] == {ext_c, scan_code}) begin
        hit     = 1'b1;
        hit_idx = LIW'(i);
      end
    end
  end

  always_comb begin
    press_evt   = make_c && hit && !key_held_q[hit_idx];
    release_evt = brk_c && hit && key_held_q[hit_idx];
    unknown_evt = (make_c || brk_c) && !hit;
    tick_evt    = press_evt || release_evt || unknown_evt;
    rep_fire    = REP_ON && rep_act_q &&
                  (rep_phase_q ? (rep_cnt_q == CW'(REPEAT_RATE - 1))
                               : (rep_cnt_q == CW'(REPEAT_DELAY - 1)));
  end

  // Key state and auto-repeat. A repeat that coincides with a tick event is
  // dropped, but its counter still restarts.
  always_comb begin
    key_held_d    = key_held_q;
    key_press_d   = '0;
    key_release_d = '0;
    last_idx_d    = last_idx_q;
    unknown_d     = unknown_evt;
    rep_cnt_d     = rep_cnt_q;
    rep_act_d     = rep_act_q;
    rep_phase_d   = rep_phase_q;

    if (rep_act_q) rep_cnt_d = rep_fire ? '0 : sat_inc(rep_cnt_q);
    if (rep_fire && !tick_evt) begin
      key_press_d[last_idx_q] = 1'b1;
      rep_phase_d             = 1'b1;
    end

    if (press_evt) begin
      key_held_d[hit_idx]  = 1'b1;
      key_press_d[hit_idx] = 1'b1;
      last_idx_d           = hit_idx;
      rep_cnt_d            = '0;
      rep_act_d            = REP_ON;
      rep_phase_d          = 1'b0;
    end else if (release_evt) begin
      key_held_d[hit_idx]    = 1'b0;
      key_release_d[hit_idx] = 1'b1;
      if (hit_idx == last_idx_q) begin
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
      end
    end
  end

  // ---- stage: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      key_held_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      last_idx_q    <= '0;
      unknown_q     <= 1'b0;
      rep_cnt_q     <= '0;
      rep_act_q     <= 1'b0;
      rep_phase_q   <= 1'b0;
    end else begin
      key_held_q    <= key_held_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      last_idx_q    <= last_idx_d;
      unknown_q     <= unknown_d;
      rep_cnt_q     <= rep_cnt_d;
      rep_act_q     <= rep_act_d;
      rep_phase_q   <= rep_phase_d;
    end
  end

  assign key_held     = key_held_q;
  assign key_press    = key_press_q;
  assign key_release  = key_release_q;
  assign any_held     = |key_held_q;
  assign last_idx     = last_idx_q;
  assign unknown_tick = unknown_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with auto-repeat on (DELAY=100, RATE=20)
// and a short prefix timeout (40 cycles).

module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] scan_code;
  logic [7:0] key_held;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic       any_held;
  logic [2:0] last_idx;
  logic       unknown_tick;

  int n_assert = 0;
  int n_fail   = 0;
  int pc;
  int pt[4];

  ps2_key_tracker #(
    .NUM_KEYS(8),
    .REPEAT_EN(1),
    .REPEAT_DELAY(100),
    .REPEAT_RATE(20),
    .PREFIX_TIMEOUT(40)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_done_tick(rx_done_tick),
    .scan_code(scan_code),
    .key_held(key_held),
    .key_press(key_press),
    .key_release(key_release),
    .any_held(any_held),
    .last_idx(last_idx),
    .unknown_tick(unknown_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns one cycle later with the result visible.
  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    scan_code    = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
    scan_code    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    scan_code    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_held", key_held, 8'h00);
    chk("rst_press", key_press, 8'h00);
    chk("rst_release", key_release, 8'h00);
    chk("rst_any", any_held, 1'b0);
    chk("rst_last", last_idx, 3'd0);
    chk("rst_unknown", unknown_tick, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Plain make and break of C
    send(8'h21);
    chk("t1_press", key_press, 8'h01);
    chk("t1_held", key_held, 8'h01);
    chk("t1_any", any_held, 1'b1);
    idle(1);
    chk("t1_press_single", key_press, 8'h00);
    send(8'hF0);
    chk("t1_prefix_quiet", key_release, 8'h00);
    send(8'h21);
    chk("t1_release", key_release, 8'h01);
    chk("t1_held_clr", key_held, 8'h00);
    chk("t1_any_clr", any_held, 1'b0);
    idle(1);
    chk("t1_release_single", key_release, 8'h00);
    send(8'hF0);
    send(8'h21);
    chk("t1_brk_not_held", key_release, 8'h00);
    chk("t1_brk_not_held_unk", unknown_tick, 1'b0);

    // Housekeeping byte in IDLE is ignored
    send(8'hAA);
    chk("ign_press", key_press, 8'h00);
    chk("ign_unknown", unknown_tick, 1'b0);
    send(8'h21);
    chk("ign_then_make", key_press, 8'h01);
    send(8'hF0);
    send(8'h21);
    chk("ign_release", key_release, 8'h01);

    // Extended Up vs plain 75
    send(8'hE0);
    send(8'h75);
    chk("t2_press", key_press, 8'h10);
    chk("t2_last", last_idx, 3'd4);
    send(8'h75);
    chk("t2_unknown", unknown_tick, 1'b1);
    chk("t2_unknown_press", key_press, 8'h00);
    chk("t2_unknown_held", key_held, 8'h10);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t2_release", key_release, 8'h10);
    chk("t2_held_clr", key_held, 8'h00);

    // Typematic resends of T
    pc = 0;
    for (int k = 0; k < 5; k++) begin
      send(8'h2C);
      if (key_press[1]) pc++;
    end
    chk("t3_press_count", pc, 1);
    chk("t3_held", key_held, 8'h02);
    chk("t3_last", last_idx, 3'd1);
    send(8'hF0);
    send(8'h2C);
    chk("t3_release", key_release, 8'h02);

    // Auto-repeat timing on Enter
    send(8'h5A);
    pc = 0;
    for (int i = 0; i < 146; i++) begin
      if (key_press[3]) begin
        if (pc < 4) pt[pc] = i;
        pc++;
      end
      @(negedge clk);
    end
    chk("t4_pulse_count", pc, 4);
    chk("t4_press_t0", pt[0], 0);
    chk("t4_repeat_1", pt[1], 100);
    chk("t4_repeat_2", pt[2], 120);
    chk("t4_repeat_3", pt[3], 140);
    send(8'hF0);
    send(8'h5A);
    chk("t4_release", key_release, 8'h08);
    pc = 0;
    for (int i = 0; i < 200; i++) begin
      if (key_press[3]) pc++;
      @(negedge clk);
    end
    chk("t4_no_repeat_after_rel", pc, 0);

    // Repeat stops with newest key; older held key does not repeat
    send(8'h21);
    send(8'h5A);
    chk("t5_last", last_idx, 3'd3);
    chk("t5_held_both", key_held, 8'h09);
    send(8'hF0);
    send(8'h5A);
    chk("t5_held", key_held, 8'h01);
    chk("t5_release", key_release, 8'h08);
    pc = 0;
    for (int i = 0; i < 300; i++) begin
      if (key_press != 8'h00) pc++;
      @(negedge clk);
    end
    chk("t5_no_repeat", pc, 0);
    send(8'hF0);
    send(8'h21);
    chk("t5_release_c", key_held, 8'h00);

    // Prefix timeout boundary
    send(8'hE0);
    idle(39);
    send(8'h75);
    chk("t6_before_timeout", key_press, 8'h10);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t6_release", key_release, 8'h10);
    send(8'hE0);
    idle(40);
    send(8'h75);
    chk("t6_timeout_unknown", unknown_tick, 1'b1);
    chk("t6_timeout_press", key_press, 8'h00);
    chk("t6_timeout_held", key_held, 8'h00);

    // Reset discards a pending break prefix
    send(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h21);
    chk("t6_rst_make", key_press, 8'h01);
    chk("t6_rst_release", key_release, 8'h00);
    chk("t6_rst_held", key_held, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
